// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared pixel/frame constants and 3x3 window element indexing
package edge_pkg;

    localparam int PIX_W      = 12;
    localparam int IMG_WIDTH  = 128;
    localparam int IMG_HEIGHT = 128;

    // Bit offset of window element (r,k); r=0 is the oldest row, k=0 the leftmost column.
    function automatic int win_off(input int r, input int k, input int pix_w = PIX_W);
        return pix_w * (3 * r + k);
    endfunction

endpackage

// File: rtl/mem_bram.sv
// rtl/mem_bram.sv - simple dual-port block RAM with registered read and no reset on contents
module mem_bram #(
    parameter int BRAM_WIDTH = 12,
    parameter int BRAM_DEPTH = 128,
    localparam int ADDR_W    = $clog2(BRAM_DEPTH)
) (
    input  logic                  wr_clk,
    input  logic                  wr_port_en,
    input  logic                  i_wr,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [BRAM_WIDTH-1:0] wr_data,
    input  logic                  rd_clk,
    input  logic                  rd_port_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [BRAM_WIDTH-1:0] rd_data
);

    logic [BRAM_WIDTH-1:0] mem [BRAM_DEPTH];

    always_ff @(posedge wr_clk) begin
        if (wr_port_en && i_wr) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data holds while the read port is disabled.
    always_ff @(posedge rd_clk) begin
        if (rd_port_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// rtl/window_3x3_gen.sv - streaming 3x3 neighbourhood generator over two line buffers
module window_3x3_gen #(
    parameter int PIX_W      = edge_pkg::PIX_W,
    parameter int IMG_WIDTH  = edge_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = edge_pkg::IMG_HEIGHT,
    localparam int COL_W     = $clog2(IMG_WIDTH),
    localparam int ROW_W     = $clog2(IMG_HEIGHT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic [PIX_W-1:0]   i_pixel,
    input  logic               i_sof,
    output logic               o_valid,
    output logic [9*PIX_W-1:0] o_window,
    output logic [ROW_W-1:0]   o_row,
    output logic [COL_W-1:0]   o_col,
    output logic               o_frame_done
);

    import edge_pkg::win_off;

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col, cur_col, s1_col;
    logic [ROW_W-1:0] row, cur_row, s1_row;
    logic             s1_valid;
    logic [PIX_W-1:0] s1_pixel;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic [PIX_W-1:0] win [3][3];

    // A start-of-frame pixel is (0,0) regardless of where the counters were.
    always_comb begin
        cur_col = i_sof ? '0 : col;
        cur_row = i_sof ? '0 : row;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (i_valid) begin
            if (cur_col == COL_MAX) begin
                col <= '0;
                row <= (cur_row == ROW_MAX) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col <= cur_col + COL_W'(1);
                row <= cur_row;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_pixel <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_pixel <= i_pixel;
                s1_col   <= cur_col;
                s1_row   <= cur_row;
            end
        end
    end

    // Writes land one cycle after the read of the same column, so ports never collide.
    mem_bram #(.BRAM_WIDTH(PIX_W), .BRAM_DEPTH(IMG_WIDTH)) u_lb0 (
        .wr_clk     (clk),
        .wr_port_en (s1_valid),
        .i_wr       (s1_valid),
        .wr_addr    (s1_col),
        .wr_data    (s1_pixel),
        .rd_clk     (clk),
        .rd_port_en (i_valid),
        .rd_addr    (cur_col),
        .rd_data    (lb0_rd)
    );

    mem_bram #(.BRAM_WIDTH(PIX_W), .BRAM_DEPTH(IMG_WIDTH)) u_lb1 (
        .wr_clk     (clk),
        .wr_port_en (s1_valid),
        .i_wr       (s1_valid),
        .wr_addr    (s1_col),
        .wr_data    (lb0_rd),
        .rd_clk     (clk),
        .rd_port_en (i_valid),
        .rd_addr    (cur_col),
        .rd_data    (lb1_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    win[r][k] <= '0;
                end
            end
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            o_row        <= '0;
            o_col        <= '0;
        end else begin
            o_valid      <= s1_valid && (s1_row >= ROW_W'(2)) && (s1_col >= COL_W'(2));
            o_frame_done <= s1_valid && (s1_row == ROW_MAX) && (s1_col == COL_MAX);
            if (s1_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb1_rd;
                win[1][2] <= lb0_rd;
                win[2][2] <= s1_pixel;
                o_row     <= s1_row - ROW_W'(1);
                o_col     <= s1_col - COL_W'(1);
            end
        end
    end

    always_comb begin
        o_window = '0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                o_window[win_off(r, k, PIX_W) +: PIX_W] = win[r][k];
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb/tb_window_3x3_gen.sv - randomized and directed checks of window_3x3_gen against a frame-image model
module tb_window_3x3_gen;

    localparam int PW = 12;
    localparam int WS = 4;
    localparam int HS = 4;
    localparam int WL = 128;
    localparam int HL = 128;

    logic clk = 1'b0;
    logic rst;

    logic           iv_s, isof_s, ov_s, od_s;
    logic [PW-1:0]  ip_s;
    logic [9*PW-1:0] ow_s;
    logic [1:0]     orow_s, ocol_s;

    logic           iv_l, isof_l, ov_l, od_l;
    logic [PW-1:0]  ip_l;
    logic [9*PW-1:0] ow_l;
    logic [6:0]     orow_l, ocol_l;

    window_3x3_gen #(.PIX_W(PW), .IMG_WIDTH(WS), .IMG_HEIGHT(HS)) dut_s (
        .clk(clk), .rst(rst), .i_valid(iv_s), .i_pixel(ip_s), .i_sof(isof_s),
        .o_valid(ov_s), .o_window(ow_s), .o_row(orow_s), .o_col(ocol_s), .o_frame_done(od_s)
    );

    window_3x3_gen #(.PIX_W(PW), .IMG_WIDTH(WL), .IMG_HEIGHT(HL)) dut_l (
        .clk(clk), .rst(rst), .i_valid(iv_l), .i_pixel(ip_l), .i_sof(isof_l),
        .o_valid(ov_l), .o_window(ow_l), .o_row(orow_l), .o_col(ocol_l), .o_frame_done(od_l)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9*PW-1:0] win;
        int              row;
        int              col;
        bit              done;
        longint          due;
    } exp_t;

    int     tests = 0;
    int     fails = 0;
    longint ecount = 0;

    exp_t q_s[$];
    exp_t q_l[$];
    logic [9*PW-1:0] got_s[$];
    logic [PW-1:0] img_s [HS][WS];
    logic [PW-1:0] img_l [HL][WL];
    int mr_s, mc_s, mr_l, mc_l;
    int nwin_s, ndone_s, nwin_l, ndone_l;

    always @(posedge clk) ecount++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9*PW-1:0] mkwin(input int base);
        logic [9*PW-1:0] w;
        w = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int k = 0; k < 3; k++)
                w[PW*(3*rr+k) +: PW] = PW'(base + 16*rr + k);
        return w;
    endfunction

    // Model: place each pixel in the frame image; every interior position yields the window around its top-left neighbour.
    task automatic model_s(input logic [PW-1:0] pix, input bit sof, input longint due);
        exp_t e;
        if (sof) begin mr_s = 0; mc_s = 0; end
        img_s[mr_s][mc_s] = pix;
        if (mr_s >= 2 && mc_s >= 2) begin
            e.win = '0;
            for (int rr = 0; rr < 3; rr++)
                for (int k = 0; k < 3; k++)
                    e.win[PW*(3*rr+k) +: PW] = img_s[mr_s-2+rr][mc_s-2+k];
            e.row = mr_s - 1; e.col = mc_s - 1;
            e.done = (mr_s == HS-1) && (mc_s == WS-1);
            e.due = due;
            q_s.push_back(e);
        end
        mc_s++;
        if (mc_s == WS) begin mc_s = 0; mr_s = (mr_s == HS-1) ? 0 : mr_s + 1; end
    endtask

    task automatic model_l(input logic [PW-1:0] pix, input bit sof, input longint due);
        exp_t e;
        if (sof) begin mr_l = 0; mc_l = 0; end
        img_l[mr_l][mc_l] = pix;
        if (mr_l >= 2 && mc_l >= 2) begin
            e.win = '0;
            for (int rr = 0; rr < 3; rr++)
                for (int k = 0; k < 3; k++)
                    e.win[PW*(3*rr+k) +: PW] = img_l[mr_l-2+rr][mc_l-2+k];
            e.row = mr_l - 1; e.col = mc_l - 1;
            e.done = (mr_l == HL-1) && (mc_l == WL-1);
            e.due = due;
            q_l.push_back(e);
        end
        mc_l++;
        if (mc_l == WL) begin mc_l = 0; mr_l = (mr_l == HL-1) ? 0 : mr_l + 1; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_s(input logic [PW-1:0] pix, input bit sof);
        iv_s = 1'b1; ip_s = pix; isof_s = sof;
        model_s(pix, sof, ecount + 2);
        @(posedge clk); #1;
        iv_s = 1'b0; isof_s = 1'b0;
    endtask

    task automatic send_l(input logic [PW-1:0] pix, input bit sof);
        iv_l = 1'b1; ip_l = pix; isof_l = sof;
        model_l(pix, sof, ecount + 2);
        @(posedge clk); #1;
        iv_l = 1'b0; isof_l = 1'b0;
    endtask

    task automatic frame_s(input int base, input bit sof, input int maxgap);
        for (int r = 0; r < HS; r++)
            for (int c = 0; c < WS; c++) begin
                send_s(PW'(base + 16*r + c), sof && r == 0 && c == 0);
                if (maxgap > 0) idle($urandom_range(0, maxgap));
            end
    endtask

    task automatic clear_s();
        nwin_s = 0; ndone_s = 0; got_s.delete();
    endtask

    always @(negedge clk) begin
        bit ev;
        ev = (q_s.size() > 0) && (q_s[0].due == ecount);
        chk("s_valid", ov_s, ev);
        if (ov_s && ev) begin
            chk("s_window", ow_s, q_s[0].win);
            chk("s_row", orow_s, q_s[0].row);
            chk("s_col", ocol_s, q_s[0].col);
            chk("s_done", od_s, q_s[0].done);
            got_s.push_back(ow_s);
            nwin_s++;
            if (od_s) ndone_s++;
            void'(q_s.pop_front());
        end else begin
            chk("s_done_idle", od_s, 1'b0);
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = (q_l.size() > 0) && (q_l[0].due == ecount);
        chk("l_valid", ov_l, ev);
        if (ov_l && ev) begin
            chk("l_window", ow_l, q_l[0].win);
            chk("l_row", orow_l, q_l[0].row);
            chk("l_col", ocol_l, q_l[0].col);
            chk("l_done", od_l, q_l[0].done);
            nwin_l++;
            if (od_l) ndone_l++;
            void'(q_l.pop_front());
        end else begin
            chk("l_done_idle", od_l, 1'b0);
        end
    end

    initial begin
        rst = 1'b1;
        iv_s = 0; isof_s = 0; ip_s = '0;
        iv_l = 0; isof_l = 0; ip_l = '0;
        mr_s = 0; mc_s = 0; mr_l = 0; mc_l = 0;
        nwin_l = 0; ndone_l = 0;
        clear_s();
        idle(2);
        chk("rst_valid", ov_s, 1'b0);
        chk("rst_done", od_s, 1'b0);
        chk("rst_window", ow_s, '0);
        chk("rst_row", orow_s, '0);
        chk("rst_col", ocol_s, '0);
        chk("rst_l_window", ow_l, '0);
        rst = 1'b0;
        idle(2);

        // continuous 4x4 frame
        clear_s();
        frame_s(0, 1'b1, 0);
        idle(4);
        chk("a_count", nwin_s, 4);
        chk("a_done_count", ndone_s, 1);
        chk("a_first_win", (got_s.size() > 0) ? got_s[0] : '0, mkwin(0));

        // same frame with random idle gaps
        clear_s();
        frame_s(0, 1'b1, 3);
        idle(4);
        chk("b_count", nwin_s, 4);
        chk("b_done_count", ndone_s, 1);
        chk("b_first_win", (got_s.size() > 0) ? got_s[0] : '0, mkwin(0));

        // back-to-back frames, second via row wrap
        clear_s();
        frame_s(0, 1'b1, 0);
        frame_s(100, 1'b0, 0);
        idle(4);
        chk("c_count", nwin_s, 8);
        chk("c_done_count", ndone_s, 2);
        chk("c_frame2_first", (got_s.size() > 4) ? got_s[4] : '0, mkwin(100));

        // reset after pixel (2,1)
        for (int i = 0; i < 10; i++) send_s(PW'(16*(i/4) + i%4), i == 0);
        rst = 1'b1;
        q_s.delete(); mr_s = 0; mc_s = 0;
        #1;
        chk("d_rst_valid", ov_s, 1'b0);
        idle(2);
        rst = 1'b0;
        clear_s();
        idle(1);
        frame_s(200, 1'b0, 0);
        idle(4);
        chk("d_count", nwin_s, 4);
        chk("d_done_count", ndone_s, 1);
        chk("d_first_win", (got_s.size() > 0) ? got_s[0] : '0, mkwin(200));

        // i_sof reasserted at (1,2)
        clear_s();
        for (int i = 0; i < 6; i++) send_s(PW'(300 + 16*(i/4) + i%4), i == 0);
        frame_s(400, 1'b1, 0);
        idle(4);
        chk("e_count", nwin_s, 4);
        chk("e_done_count", ndone_s, 1);
        chk("e_first_win", (got_s.size() > 0) ? got_s[0] : '0, mkwin(400));

        // default-size frame with random pixels
        for (int r = 0; r < HL; r++)
            for (int c = 0; c < WL; c++)
                send_l(PW'($urandom), r == 0 && c == 0);
        idle(4);
        chk("f_count", nwin_l, 15876);
        chk("f_done_count", ndone_l, 1);

        chk("s_queue_empty", q_s.size(), 0);
        chk("l_queue_empty", q_l.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
